// File: rtl/brq_pkg.sv
// Shared types and helpers for the brq instruction-fetch path.
//   fetch_entry_t  : one buffered fetch response word {rdata, err, valid}
//   is_compressed  : RVC test on the low halfword of an instruction
package brq_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        valid;
    } fetch_entry_t;

    // An instruction is 16-bit whenever its two lowest opcode bits are not 2'b11.
    function automatic logic is_compressed(input logic [15:0] instr_lo);
        return instr_lo[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/brq_ifu_fetch_fifo.sv
// Fetch FIFO between the instruction bus response path and the IF stage.
// Buffers word-aligned 32-bit fetch responses and presents one realigned
// instruction (16-bit or 32-bit, possibly straddling a word boundary) per
// output handshake. Bus errors are propagated, including the case where only
// the second halfword of an unaligned 32-bit instruction faulted.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clear_i, addr_i      flush all entries and restart output PC at addr_i
//   in_valid_i/in_ready_o, in_rdata_i, in_err_i   fetch response word in
//   count_o              number of valid word entries
//   out_valid_o/out_ready_i, out_rdata_o, out_addr_o,
//   out_err_o, out_err_plus2_o                     realigned instruction out
module brq_ifu_fetch_fifo
    import brq_pkg::*;
#(
    parameter int unsigned Depth = 3,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic [31:0]     addr_i,
    input  logic            in_valid_i,
    input  logic [31:0]     in_rdata_i,
    input  logic            in_err_i,
    output logic            in_ready_o,
    output logic [CntW-1:0] count_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [31:0]     out_rdata_o,
    output logic [31:0]     out_addr_o,
    output logic            out_err_o,
    output logic            out_err_plus2_o
);

    fetch_entry_t    entries_q [Depth];
    fetch_entry_t    entries_d [Depth];
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     addr_q, addr_d;

    logic            unaligned;
    logic [15:0]     lo_half;
    logic            instr_compressed;
    logic            instr_valid;
    logic            push, consume, pop;
    logic [CntW-1:0] wr_idx;
    logic [31:0]     stable_mask;
    logic            unused_addr0;

    assign unused_addr0 = addr_i[0];

    // Realignment: entries other than E0 are kept zeroed while invalid, so
    // E1.err can be used directly without gating on E1.valid.
    always_comb begin
        unaligned        = addr_q[1];
        lo_half          = unaligned ? entries_q[0].rdata[31:16] : entries_q[0].rdata[15:0];
        instr_compressed = is_compressed(lo_half);

        out_rdata_o     = entries_q[0].rdata;
        instr_valid     = entries_q[0].valid;
        out_err_o       = entries_q[0].err;
        out_err_plus2_o = 1'b0;

        if (unaligned) begin
            out_rdata_o = {entries_q[1].rdata[15:0], entries_q[0].rdata[31:16]};
            if (!instr_compressed) begin
                // A faulted E0 is reported without waiting for the second word.
                instr_valid     = entries_q[0].valid & (entries_q[1].valid | entries_q[0].err);
                out_err_o       = entries_q[0].err | entries_q[1].err;
                out_err_plus2_o = ~entries_q[0].err & entries_q[1].err;
            end
        end

        out_valid_o = instr_valid & ~clear_i;
        out_addr_o  = addr_q;
        count_o     = cnt_q;
        in_ready_o  = cnt_q < CntW'(Depth);
    end

    // Aligned compressed instructions leave the upper halfword in E0, so only
    // that case consumes without popping.
    always_comb begin
        push    = in_valid_i & in_ready_o & ~clear_i;
        consume = out_valid_o & out_ready_i & ~clear_i;
        pop     = consume & (unaligned | ~instr_compressed);
        wr_idx  = cnt_q - CntW'(pop);

        for (int unsigned i = 0; i < Depth; i++) begin
            entries_d[i] = entries_q[i];
        end
        if (pop) begin
            for (int unsigned i = 0; i + 1 < Depth; i++) begin
                entries_d[i] = entries_q[i + 1];
            end
            entries_d[Depth-1] = '0;
        end
        if (push) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                if (CntW'(i) == wr_idx) begin
                    entries_d[i] = '{rdata: in_rdata_i, err: in_err_i, valid: 1'b1};
                end
            end
        end

        cnt_d  = cnt_q - CntW'(pop) + CntW'(push);
        addr_d = consume ? addr_q + (instr_compressed ? 32'd2 : 32'd4) : addr_q;

        if (clear_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                entries_d[i] = '0;
            end
            cnt_d  = '0;
            addr_d = {addr_i[31:1], 1'b0};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                entries_q[i] <= '0;
            end
            cnt_q  <= '0;
            addr_q <= '0;
        end else begin
            for (int unsigned i = 0; i < Depth; i++) begin
                entries_q[i] <= entries_d[i];
            end
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
        end
    end

    // Bits of out_rdata_o that carry meaning: low half for compressed, none
    // once the instruction has faulted (consumer squashes it).
    always_comb begin
        if (instr_compressed) begin
            stable_mask = 32'h0000_FFFF;
        end else if (out_err_o) begin
            stable_mask = '0;
        end else begin
            stable_mask = '1;
        end
    end

    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q <= CntW'(Depth));

    a_no_overflow_push: assert property (@(posedge clk_i) disable iff (!rst_ni)
        in_valid_i |-> in_ready_o);

    a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_o && !out_ready_i && !clear_i) |=>
            (clear_i || (out_valid_o && $stable(out_addr_o) && $stable(out_err_o) &&
                         $stable(out_err_plus2_o) &&
                         ((out_rdata_o & $past(stable_mask)) == $past(out_rdata_o & stable_mask)))));

    for (genvar g = 1; g < Depth; g++) begin : g_contig
        a_contiguous: assert property (@(posedge clk_i) disable iff (!rst_ni)
            entries_q[g].valid |-> entries_q[g-1].valid);
    end

endmodule

// File: tb/tb_brq_ifu_fetch_fifo.sv
module tb_brq_ifu_fetch_fifo;

    localparam int unsigned Depth = 3;
    localparam int unsigned CntW  = $clog2(Depth + 1);

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            clear_i;
    logic [31:0]     addr_i;
    logic            in_valid_i;
    logic [31:0]     in_rdata_i;
    logic            in_err_i;
    logic            in_ready_o;
    logic [CntW-1:0] count_o;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [31:0]     out_rdata_o;
    logic [31:0]     out_addr_o;
    logic            out_err_o;
    logic            out_err_plus2_o;

    brq_ifu_fetch_fifo #(.Depth(Depth)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .addr_i         (addr_i),
        .in_valid_i     (in_valid_i),
        .in_rdata_i     (in_rdata_i),
        .in_err_i       (in_err_i),
        .in_ready_o     (in_ready_o),
        .count_o        (count_o),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_rdata_o    (out_rdata_o),
        .out_addr_o     (out_addr_o),
        .out_err_o      (out_err_o),
        .out_err_plus2_o(out_err_plus2_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic [31:0] mask;
        logic [31:0] addr;
        logic        err;
        logic        plus2;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_instr(input string name, input logic [31:0] rdata, input logic [31:0] mask,
                                input logic [31:0] addr, input logic err, input logic plus2);
        exp_t e;
        e.name = name; e.rdata = rdata; e.mask = mask; e.addr = addr; e.err = err; e.plus2 = plus2;
        sb.push_back(e);
    endtask

    // Monitor: every output handshake is matched against the next expectation.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && out_valid_o === 1'b1 && out_ready_i === 1'b1 && clear_i === 1'b0) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_handshake: got addr 0x%08h expected no instruction", out_addr_o);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_addr"}, out_addr_o, mon_e.addr);
                chk({mon_e.name, "_rdata"}, out_rdata_o & mon_e.mask, mon_e.rdata & mon_e.mask);
                chk({mon_e.name, "_err"}, {31'b0, out_err_o}, {31'b0, mon_e.err});
                chk({mon_e.name, "_plus2"}, {31'b0, out_err_plus2_o}, {31'b0, mon_e.plus2});
            end
        end
    end

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_clear(input logic [31:0] a);
        clear_i = 1'b1;
        addr_i  = a;
        cycle();
        clear_i = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] d, input logic e);
        in_valid_i = 1'b1;
        in_rdata_i = d;
        in_err_i   = e;
        cycle();
        in_valid_i = 1'b0;
        in_err_i   = 1'b0;
    endtask

    task automatic consume(input int unsigned n);
        out_ready_i = 1'b1;
        repeat (n) cycle();
        out_ready_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0; addr_i = '0;
        in_valid_i = 1'b0; in_rdata_i = '0; in_err_i = 1'b0; out_ready_i = 1'b0;
        #2;
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_in_ready", {31'b0, in_ready_o}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid_o}, 32'd0);
        chk("rst_out_addr", out_addr_o, 32'h0);
        chk("rst_out_err", {31'b0, out_err_o}, 32'd0);
        chk("rst_out_plus2", {31'b0, out_err_plus2_o}, 32'd0);
        #1 rst_ni = 1'b1;

        // Aligned 32-bit instruction, no bypass from input to output.
        do_clear(32'h0000_0100);
        in_valid_i = 1'b1; in_rdata_i = 32'h0000_0013; #1;
        chk("no_bypass_valid", {31'b0, out_valid_o}, 32'd0);
        cycle(); in_valid_i = 1'b0;
        chk("t1_valid", {31'b0, out_valid_o}, 32'd1);
        chk("t1_count", 32'(count_o), 32'd1);
        expect_instr("t1_addi", 32'h0000_0013, 32'hFFFF_FFFF, 32'h0000_0100, 1'b0, 1'b0);
        consume(1);
        chk("t1_count_after", 32'(count_o), 32'd0);
        chk("t1_addr_after", out_addr_o, 32'h0000_0104);

        // Two compressed instructions in one word: only the second pops.
        do_clear(32'h0000_0200);
        push_word(32'h4501_4501, 1'b0);
        expect_instr("t2_c0", 32'h0000_4501, 32'h0000_FFFF, 32'h0000_0200, 1'b0, 1'b0);
        expect_instr("t2_c1", 32'h0000_4501, 32'h0000_FFFF, 32'h0000_0202, 1'b0, 1'b0);
        consume(1);
        chk("t2_count_mid", 32'(count_o), 32'd1);
        consume(1);
        chk("t2_count_after", 32'(count_o), 32'd0);
        chk("t2_addr_after", out_addr_o, 32'h0000_0204);

        // 32-bit instruction straddling a word boundary, then compressed at 0x306.
        do_clear(32'h0000_0302);
        push_word(32'h0013_0001, 1'b0);
        chk("t3_wait_second_half", {31'b0, out_valid_o}, 32'd0);
        push_word(32'hABCD_0000, 1'b0);
        chk("t3_count", 32'(count_o), 32'd2);
        expect_instr("t3_straddle", 32'h0000_0013, 32'hFFFF_FFFF, 32'h0000_0302, 1'b0, 1'b0);
        expect_instr("t3_c", 32'h0000_ABCD, 32'h0000_FFFF, 32'h0000_0306, 1'b0, 1'b0);
        consume(2);
        chk("t3_count_after", 32'(count_o), 32'd0);
        chk("t3_addr_after", out_addr_o, 32'h0000_0308);

        // Error only in the second halfword, then error in the first.
        do_clear(32'h0000_0402);
        push_word(32'h0013_0000, 1'b0);
        chk("t4_wait_e1", {31'b0, out_valid_o}, 32'd0);
        push_word(32'h1234_5678, 1'b1);
        chk("t4_valid", {31'b0, out_valid_o}, 32'd1);
        expect_instr("t4_plus2", 32'h5678_0013, 32'h0000_0000, 32'h0000_0402, 1'b1, 1'b1);
        expect_instr("t4_e1c", 32'h0000_1234, 32'h0000_0000, 32'h0000_0406, 1'b1, 1'b0);
        consume(2);
        chk("t4_count_after", 32'(count_o), 32'd0);
        chk("t4_addr_after", out_addr_o, 32'h0000_0408);
        do_clear(32'h0000_0402);
        push_word(32'h0013_0000, 1'b1);
        chk("t4b_valid_no_e1", {31'b0, out_valid_o}, 32'd1);
        expect_instr("t4b_err", 32'h0000_0013, 32'h0000_0000, 32'h0000_0402, 1'b1, 1'b0);
        consume(1);
        chk("t4b_count_after", 32'(count_o), 32'd0);

        // Full FIFO, simultaneous push/pop, clear with ready and with a pending word.
        do_clear(32'h0000_0500);
        push_word(32'h0000_0013, 1'b0);
        push_word(32'h0010_0093, 1'b0);
        push_word(32'h0020_0113, 1'b0);
        chk("t5_full_count", 32'(count_o), 32'd3);
        chk("t5_full_ready", {31'b0, in_ready_o}, 32'd0);
        expect_instr("t5_w0", 32'h0000_0013, 32'hFFFF_FFFF, 32'h0000_0500, 1'b0, 1'b0);
        expect_instr("t5_w1", 32'h0010_0093, 32'hFFFF_FFFF, 32'h0000_0504, 1'b0, 1'b0);
        consume(1);
        chk("t5_count_pop", 32'(count_o), 32'd2);
        out_ready_i = 1'b1;
        push_word(32'h0030_0193, 1'b0);
        out_ready_i = 1'b0;
        chk("t5_count_pushpop", 32'(count_o), 32'd2);
        chk("t5_addr_pushpop", out_addr_o, 32'h0000_0508);
        push_word(32'h0040_0213, 1'b0);
        chk("t5_refill_ready", {31'b0, in_ready_o}, 32'd0);
        clear_i = 1'b1; addr_i = 32'h0000_0600; out_ready_i = 1'b1; #1;
        chk("t5_clear_forces_invalid", {31'b0, out_valid_o}, 32'd0);
        cycle();
        clear_i = 1'b0; out_ready_i = 1'b0;
        chk("t5_clear_count", 32'(count_o), 32'd0);
        chk("t5_clear_addr", out_addr_o, 32'h0000_0600);
        clear_i = 1'b1; addr_i = 32'h0000_0700;
        in_valid_i = 1'b1; in_rdata_i = 32'h0000_0013;
        cycle();
        clear_i = 1'b0; in_valid_i = 1'b0;
        chk("t5_clear_drop_count", 32'(count_o), 32'd0);
        chk("t5_clear_drop_valid", {31'b0, out_valid_o}, 32'd0);
        chk("t5_clear_drop_addr", out_addr_o, 32'h0000_0700);

        // Address wrap-around for 32-bit and 16-bit consumes; addr_i[0] ignored.
        do_clear(32'hFFFF_FFFC);
        push_word(32'h0000_0013, 1'b0);
        expect_instr("t6_wrap32", 32'h0000_0013, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b0, 1'b0);
        consume(1);
        chk("t6_wrap32_addr", out_addr_o, 32'h0000_0000);
        do_clear(32'hFFFF_FFFF);
        chk("t6_addr_bit0", out_addr_o, 32'hFFFF_FFFE);
        push_word(32'h0001_0000, 1'b0);
        expect_instr("t6_wrap16", 32'h0000_0001, 32'h0000_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
        consume(1);
        chk("t6_wrap16_addr", out_addr_o, 32'h0000_0000);
        chk("t6_wrap16_count", 32'(count_o), 32'd0);

        cycle();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
